// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first.
// Results appear in diff/borrow with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             d_bit;
    logic             br_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Full-subtractor step on the current LSBs
    assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_q >> 1;
                res_d[WIDTH-1] = d_bit;
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d   = res_d;
                    borrow_d = br_nxt;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Expected values are computed here from the operands.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input bit tog, input string tag);
        logic [7:0] ed;
        logic       eb;
        int         n;
        ed = av - bv;
        eb = (av < bv);
        a = av;
        b = bv;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done && n < 20) begin
            if (tog) begin
                a = ~a;
                b = ~b;
            end
            cyc();
            n++;
        end
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow, eb);
        cyc();
        chk({tag, "_done_off"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int         last;
        int         npulse;
        int         lowrun;
        int         ndone;
        logic [7:0] ra;
        logic [7:0] rb;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        start1 = 1'b0;
        a1 = '0;
        b1 = '0;
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);

        // Reset wins over a simultaneous start
        a = 8'h05;
        b = 8'h01;
        start = 1'b1;
        cyc();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        cyc();
        chk("rst_prio_busy2", busy, 0);

        run_op(8'h5A, 8'h3C, 1'b0, "basic");
        run_op(8'h00, 8'h01, 1'b0, "under");
        run_op(8'hFF, 8'h00, 1'b0, "max");

        // Idle with new operands: outputs hold
        a = 8'h11;
        b = 8'h22;
        cyc();
        cyc();
        cyc();
        chk("hold_diff", diff, 8'hFF);
        chk("hold_borrow", borrow, 0);

        run_op(8'h80, 8'h80, 1'b1, "toggle");

        // start held high: periodic operation
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        last = -1;
        npulse = 0;
        lowrun = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done) begin
                if (last >= 0) chk("period", i - last, 10);
                last = i;
                npulse++;
            end
            if (!busy) begin
                lowrun++;
            end else begin
                if (lowrun > 0 && npulse > 0) chk("busy_gap", lowrun, 1);
                lowrun = 0;
            end
        end
        start = 1'b0;
        chk("npulse", npulse, 4);
        chk("held_diff", diff, 8'h22);
        cyc();
        chk("held_idle", busy, 0);

        // Reset during the 4th SHIFT cycle aborts the operation
        a = 8'h77;
        b = 8'h07;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        run_op(8'h10, 8'h20, 1'b0, "post_abort");

        for (int k = 0; k < 300; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 1'b0, "rnd");
        end

        // WIDTH=1: all four operand combinations
        for (int i = 0; i < 4; i++) begin
            a1 = 1'(i >> 1);
            b1 = 1'(i);
            start1 = 1'b1;
            cyc();
            start1 = 1'b0;
            chk("w1_busy", busy1, 1);
            cyc();
            chk("w1_done", done1, 1);
            chk("w1_diff", diff1, 1'(a1 ^ b1));
            chk("w1_borrow", borrow1, (a1 < b1) ? 1 : 0);
            cyc();
            chk("w1_done_off", done1, 0);
            chk("w1_idle", busy1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
